// File: rtl/vga_timing_pkg.sv
// Shared raster constants and types for the 640x480@60 Hz display path.
// The overlay layers import the coordinate and colour widths from here as well.
package vga_timing_pkg;

  localparam int COORD_W = 10;
  localparam int RGB_W   = 3;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [RGB_W-1:0]   rgb_t;

  // Per-pixel raster flags carried alongside the overlay pipeline.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } raster_flags_t;

endpackage

// File: rtl/sig_delay_line.sv
// Parameterised-depth, parameterised-width shift register with async clear.
// Each bit clears to its own RST_VAL so delayed sync levels come out deasserted.
module sig_delay_line #(
  parameter int               DEPTH   = 1,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign q_o = d_i;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];

      // NOTE: every stage is cleared, not just the last; a stage left holding
      // pre-reset data would replay a stale sync or blank level after release.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
        end else begin
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counter plus registered output stage; sync and blank are delayed to
// line up with the overlay layers' colour latency at the connector.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int PIPE_DELAY = 1
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  output logic [COORD_W-1:0] oVGA_X,
  output logic [COORD_W-1:0] oVGA_Y,
  output logic               oFrame_Start,
  output logic               oVBlank_Start,
  input  logic [RGB_W-1:0]   iRGB,
  output logic [RGB_W-1:0]   oVGA_RGB,
  output logic               oVGA_HS,
  output logic               oVGA_VS,
  output logic               oVGA_BLANK_n
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL >= 1024 || V_TOTAL >= 1024) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must stay below 1024");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
      $error("vga_timing_gen: PIPE_DELAY must be within 0..7");
    end
  endgenerate

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
  localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_AFTER = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_AFTER = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  coord_t        h_cnt_q, h_cnt_d;
  coord_t        v_cnt_q, v_cnt_d;
  raster_flags_t raw_flags, dly_flags;
  rgb_t          rgb_q;
  logic          hs_q, vs_q, blank_n_q;
  logic          frame_start_q, vblank_start_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_comb begin
    raw_flags.active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    raw_flags.hs     = (h_cnt_q >= HS_FIRST) && (h_cnt_q < HS_AFTER);
    raw_flags.vs     = (v_cnt_q >= VS_FIRST) && (v_cnt_q < VS_AFTER);
  end

  // PIPE_DELAY stages here plus the output register below give PIPE_DELAY+1.
  sig_delay_line #(
    .DEPTH  (PIPE_DELAY),
    .WIDTH  ($bits(raster_flags_t)),
    .RST_VAL('0)
  ) u_flag_dly (
    .clk  (iVGA_CLK),
    .rst_n(iRST_n),
    .d_i  (raw_flags),
    .q_o  (dly_flags)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      rgb_q          <= '0;
      blank_n_q      <= 1'b0;
      hs_q           <= ~HS_POL;
      vs_q           <= ~VS_POL;
    end else begin
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      // Loaded from the next count so the pulse lines up with the target X/Y.
      frame_start_q  <= (h_cnt_d == '0) && (v_cnt_d == '0);
      vblank_start_q <= (h_cnt_d == '0) && (v_cnt_d == V_ACT);
      rgb_q          <= dly_flags.active ? iRGB : '0;
      blank_n_q      <= dly_flags.active;
      hs_q           <= dly_flags.hs ? HS_POL : ~HS_POL;
      vs_q           <= dly_flags.vs ? VS_POL : ~VS_POL;
    end
  end

  assign oVGA_X        = h_cnt_q;
  assign oVGA_Y        = v_cnt_q;
  assign oFrame_Start  = frame_start_q;
  assign oVBlank_Start = vblank_start_q;
  assign oVGA_RGB      = rgb_q;
  assign oVGA_HS       = hs_q;
  assign oVGA_VS       = vs_q;
  assign oVGA_BLANK_n  = blank_n_q;

endmodule
